// File: rtl/cache_port_arbiter.sv
// Two-port (instruction fetch / data) round-robin arbiter in front of a single-ported cache.
// Also keeps saturating hit/miss statistics and a sticky stall-timeout flag.
module cache_port_arbiter #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ack,
  output logic              CPU_read_en,
  output logic              CPU_write_en,
  output logic [31:0]       CPU_addr,
  output logic [31:0]       CPU_write_din,
  input  logic [31:0]       CPU_read_dout,
  input  logic              isCacheStall,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic              timeout
);

  localparam int unsigned SC_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t          state;
  logic            last_grant;   // 1: data port completed last, 0: fetch port
  logic [SC_W-1:0] stall_cnt;
  logic            i_pend;
  logic            d_pend;
  logic            pick_d;

  // A port whose ack is on the wire this cycle still shows its old request; mask it
  // so the turnaround cycle cannot re-grant the access that just finished.
  assign i_pend = if_req & ~if_ack;
  assign d_pend = d_req & ~d_ack;
  assign pick_d = d_pend & (~i_pend | ~last_grant);

  // Arbitration FSM, captured cache command, completion and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      stall_cnt     <= '0;
      if_ack        <= 1'b0;
      d_ack         <= 1'b0;
      if_rdata      <= '0;
      d_rdata       <= '0;
      CPU_read_en   <= 1'b0;
      CPU_write_en  <= 1'b0;
      CPU_addr      <= '0;
      CPU_write_din <= '0;
      hit_cnt       <= '0;
      miss_cnt      <= '0;
      timeout       <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_pend || d_pend) begin
            stall_cnt <= '0;
            if (pick_d) begin
              state         <= GRANT_D;
              CPU_addr      <= d_addr;
              CPU_write_din <= d_wdata;
              CPU_read_en   <= ~d_we;
              CPU_write_en  <= d_we;
            end else begin
              state        <= GRANT_I;
              CPU_addr     <= if_addr;
              CPU_read_en  <= 1'b1;
              CPU_write_en <= 1'b0;
            end
          end
        end
        GRANT_I, GRANT_D: begin
          if (isCacheStall) begin
            if (stall_cnt != SC_W'(TIMEOUT)) begin
              stall_cnt <= stall_cnt + SC_W'(1);
            end
            // The stall counter reaches TIMEOUT on this edge
            if (stall_cnt >= SC_W'(TIMEOUT - 1)) begin
              timeout <= 1'b1;
            end
          end else begin
            state        <= IDLE;
            CPU_read_en  <= 1'b0;
            CPU_write_en <= 1'b0;
            if (state == GRANT_I) begin
              if_rdata   <= CPU_read_dout;
              if_ack     <= 1'b1;
              last_grant <= 1'b0;
            end else begin
              d_rdata    <= CPU_read_dout;
              d_ack      <= 1'b1;
              last_grant <= 1'b1;
            end
            if (stall_cnt == '0) begin
              if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
            end else begin
              if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state        <= IDLE;
          CPU_read_en  <= 1'b0;
          CPU_write_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cache_port_arbiter.md
CACHE_PORT_ARBITER -- requirements
Module: cache_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: stall-cycle limit for a single granted access before the timeout flag sets.
REQ-002 Parameter CNT_W, default 16: width of the hit and miss counters.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 if_req  input  1  instruction-fetch read request; held high until if_ack.
REQ-006 if_addr  input  32  instruction-fetch byte address.
REQ-007 if_rdata  output  32  instruction read data, valid in the if_ack cycle.
REQ-008 if_ack  output  1  one-cycle completion pulse for the fetch port.
REQ-009 d_req  input  1  data-port request; held high until d_ack.
REQ-010 d_we  input  1  data-port write (1) or read (0).
REQ-011 d_addr  input  32  data-port byte address.
REQ-012 d_wdata  input  32  data-port write data.
REQ-013 d_rdata  output  32  data-port read data, valid in the d_ack cycle.
REQ-014 d_ack  output  1  one-cycle completion pulse for the data port.
REQ-015 CPU_read_en  output  1  cache read enable.
REQ-016 CPU_write_en  output  1  cache write enable.
REQ-017 CPU_addr  output  32  cache address.
REQ-018 CPU_write_din  output  32  cache write data.
REQ-019 CPU_read_dout  input  32  cache read data.
REQ-020 isCacheStall  input  1  cache stall; low while an enable is high means the access completes this cycle.
REQ-021 hit_cnt  output  CNT_W  saturating count of accesses that complete in their first granted cycle.
REQ-022 miss_cnt  output  CNT_W  saturating count of accesses that stall at least one cycle.
REQ-023 timeout  output  1  sticky flag: a granted access has stalled TIMEOUT consecutive cycles.

Function
REQ-024 The arbiter SHALL have three states:
- IDLE
- GRANT_I
- GRANT_D
REQ-025 In IDLE with one request pending, the block SHALL grant that port on the next edge.
REQ-026 In IDLE with both requests pending, the block SHALL grant the port opposite last_grant (round-robin).
REQ-027 At grant, the block SHALL capture the winner's address, write flag and write data into registers; the cache outputs SHALL be driven only from these registers.
REQ-028 In GRANT_I, the block SHALL drive CPU_read_en=1 and CPU_write_en=0.
REQ-029 In GRANT_D, the block SHALL drive CPU_write_en=d_we(captured) and CPU_read_en=~d_we(captured).
REQ-030 In IDLE, both enables SHALL be 0; CPU_addr and CPU_write_din SHALL hold their last captured values.
REQ-031 In any GRANT cycle with isCacheStall=0, the block SHALL:
- register CPU_read_dout into the granted port's rdata;
- pulse that port's ack high for exactly the next cycle;
- update last_grant;
- return to IDLE.
REQ-032 Minimum latency SHALL be 2 cycles: req sampled at edge N, grant at edge N+1, ack high during cycle N+2 on a hit.
REQ-033 The IDLE turnaround SHALL prevent back-to-back grants; a port acked in cycle N SHALL be granted again no earlier than edge N+1.
REQ-034 A request deasserted during its grant SHALL NOT abort the access; the access completes and is acked.
REQ-035 if_rdata and d_rdata SHALL hold their value until the next completion on that port.
REQ-036 A per-access stall counter SHALL clear at grant and increment each GRANT cycle with isCacheStall=1.
REQ-037 timeout SHALL set when the stall counter reaches TIMEOUT and SHALL remain set until reset; the access continues regardless.
REQ-038 On completion, the block SHALL increment hit_cnt if the stall counter is 0, otherwise miss_cnt; both counters SHALL saturate at all-ones.
REQ-039 A write completion SHALL pulse d_ack; d_rdata content after a write is don't-care.

Reset
REQ-040 On rst_n low, the block SHALL asynchronously set:
- state=IDLE, last_grant=D;
- if_ack=d_ack=0, CPU_read_en=CPU_write_en=0;
- CPU_addr, CPU_write_din, if_rdata, d_rdata = 0;
- hit_cnt=miss_cnt=0, timeout=0.
REQ-041 Reset asserted mid-access SHALL abandon the access with no ack; the first tie after reset SHALL grant the I port.

Verification
REQ-042 if_req with addr 0x40 and isCacheStall=0 -> CPU_read_en high during cycle 1; if_ack high in cycle 2 with if_rdata=CPU_read_dout; hit_cnt=1.
REQ-043 if_req and d_req asserted together after reset, both hitting -> grant order I, D, I, D over repeated requests; each ack is a single cycle.
REQ-044 d_req, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, stall held for 5 cycles -> CPU_write_en high for 6 cycles with constant addr and data; d_ack once; miss_cnt=1.
REQ-045 Stall held for 64 cycles -> timeout rises at the 64th stall cycle and stays high after completion until rst_n.
REQ-046 rst_n pulsed low during GRANT_D stall -> enables drop immediately; no d_ack; counters read 0.
REQ-047 Force hit_cnt to all-ones, then one more hit -> hit_cnt unchanged.
